// File: rtl/char_row_fetch_arb.sv
// Two-requester character-row fetch: one 16-column ROM sweep per grant, codes realigned to a tag pipe.
// Grant visible 1 cycle after arbitration; data ROM_LAT cycles after address. Requests wait in IDLE.
// Define CHAR_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module char_row_fetch_arb #(
    parameter int ROM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] row0,
    input  logic [3:0] row1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic [7:0] rom_xy,
    input  logic [6:0] rom_code,
    output logic       out_valid,
    output logic       out_id,
    output logic [3:0] out_col,
    output logic [6:0] out_code,
    output logic       done0,
    output logic       done1
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [2:0] DRN_LAST = 3'(ROM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] col_q, col_d;
    logic [3:0] row_q, row_d;
    logic       id_q, id_d;
    logic [2:0] drn_q, drn_d;
    logic [7:0] xy_q, xy_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       issue;
    logic       win;
    logic       done;

    logic [ROM_LAT-1:0]      tv_q, tv_d;
    logic [ROM_LAT-1:0]      ti_q, ti_d;
    logic [ROM_LAT-1:0][3:0] tc_q, tc_d;

`ifdef CHAR_ARB_FIXED_PRIO_EN
    assign win = req1 & ~req0;
`else
    logic last_q, last_d;
    // last_q is the id served most recently; the other requester wins a tie
    assign win = req1 & (~req0 | ~last_q);
`endif

    assign issue = (state_q == ISSUE);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        id_d    = id_q;
        drn_d   = drn_q;
        xy_d    = xy_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
`ifndef CHAR_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    state_d = ISSUE;
                    col_d   = 4'h0;
                    id_d    = win;
                    row_d   = win ? row1 : row0;
                    xy_d    = {row_d, 4'h0};
                    gnt0_d  = ~win;
                    gnt1_d  = win;
`ifndef CHAR_ARB_FIXED_PRIO_EN
                    last_d  = win;
`endif
                end
            end
            ISSUE: begin
                if (col_q == 4'hF) begin
                    state_d = DRAIN;
                    drn_d   = 3'd0;
                end else begin
                    col_d = col_q + 4'd1;
                    xy_d  = {row_q, col_d};
                end
            end
            DRAIN: begin
                if (drn_q == DRN_LAST) state_d = IDLE;
                else                   drn_d   = drn_q + 3'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag pipe carries zeros outside ISSUE so out_id/out_col stay 0 between beats
    always_comb begin
        tv_d    = '0;
        ti_d    = '0;
        tc_d    = '0;
        tv_d[0] = issue;
        ti_d[0] = issue & id_q;
        tc_d[0] = issue ? col_q : 4'h0;
        for (int i = 1; i < ROM_LAT; i++) begin
            tv_d[i] = tv_q[i-1];
            ti_d[i] = ti_q[i-1];
            tc_d[i] = tc_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 4'h0;
            row_q   <= 4'h0;
            id_q    <= 1'b0;
            drn_q   <= 3'd0;
            xy_q    <= 8'h00;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            tv_q    <= '0;
            ti_q    <= '0;
            tc_q    <= '0;
`ifndef CHAR_ARB_FIXED_PRIO_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            id_q    <= id_d;
            drn_q   <= drn_d;
            xy_q    <= xy_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            tv_q    <= tv_d;
            ti_q    <= ti_d;
            tc_q    <= tc_d;
`ifndef CHAR_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign busy      = (state_q != IDLE);
    assign rom_xy    = xy_q;
    assign out_valid = tv_q[ROM_LAT-1];
    assign out_id    = ti_q[ROM_LAT-1];
    assign out_col   = tc_q[ROM_LAT-1];
    assign out_code  = rom_code;
    assign done      = out_valid & (out_col == 4'hF);
    assign done0     = done & ~out_id;
    assign done1     = done & out_id;

endmodule

// File: tb/tb_char_row_fetch_arb.sv
// Three arbiters (ROM_LAT 2, 1, 4) share stimulus; each is checked every cycle against a
// transaction-timeline model (grant cycle g, offset k = cycle - g) and a delay-line ROM.
module tb_char_row_fetch_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] row0 = 4'h0, row1 = 4'h0;

    logic [2:0]           gnt0_o, gnt1_o, busy_o, ov_o, id_o, d0_o, d1_o;
    logic [2:0][7:0]      xy_o;
    logic [2:0][3:0]      col_o;
    logic [2:0][6:0]      code_o, rc;
    logic [2:0][3:0][6:0] pipe;
    logic [18:0]          dv [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    char_row_fetch_arb #(.ROM_LAT(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .row0(row0), .row1(row1),
        .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .busy(busy_o[0]), .rom_xy(xy_o[0]), .rom_code(rc[0]),
        .out_valid(ov_o[0]), .out_id(id_o[0]), .out_col(col_o[0]), .out_code(code_o[0]),
        .done0(d0_o[0]), .done1(d1_o[0]));

    char_row_fetch_arb #(.ROM_LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .row0(row0), .row1(row1),
        .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .busy(busy_o[1]), .rom_xy(xy_o[1]), .rom_code(rc[1]),
        .out_valid(ov_o[1]), .out_id(id_o[1]), .out_col(col_o[1]), .out_code(code_o[1]),
        .done0(d0_o[1]), .done1(d1_o[1]));

    char_row_fetch_arb #(.ROM_LAT(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .row0(row0), .row1(row1),
        .gnt0(gnt0_o[2]), .gnt1(gnt1_o[2]), .busy(busy_o[2]), .rom_xy(xy_o[2]), .rom_code(rc[2]),
        .out_valid(ov_o[2]), .out_id(id_o[2]), .out_col(col_o[2]), .out_code(code_o[2]),
        .done0(d0_o[2]), .done1(d1_o[2]));

    // ROM: code = address[6:0], returned after each instance's latency
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) pipe[d] <= {pipe[d][2:0], xy_o[d][6:0]};
    end
    assign rc[0] = pipe[0][1];
    assign rc[1] = pipe[1][0];
    assign rc[2] = pipe[2][3];

    for (genvar gd = 0; gd < 3; gd++) begin : g_dv
        assign dv[gd] = {gnt0_o[gd], gnt1_o[gd], busy_o[gd], xy_o[gd], ov_o[gd], id_o[gd],
                         col_o[gd], d0_o[gd], d1_o[gd]};
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    // ---------------- reference model ----------------
    bit          m_have [3] = '{0, 0, 0};
    int          m_g    [3] = '{0, 0, 0};
    bit          m_own  [3] = '{0, 0, 0};
    logic [3:0]  m_row  [3] = '{4'h0, 4'h0, 4'h0};
    bit          m_last [3] = '{0, 0, 0};
    logic [7:0]  m_xy   [3] = '{8'h00, 8'h00, 8'h00};
    int          m_k    [3] = '{99, 99, 99};
    logic [18:0] ev     [3];
    bit          e_ov   [3];
    logic [6:0]  e_code [3];
    int          mk, lat;
    logic        w, g_e, bz_e, ov_e, dn_e;
    logic [3:0]  cl_e;

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            lat = lat_of(d);
            if (!rst_n) begin
                m_have[d] = 1'b0;
                m_last[d] = 1'b0;
                m_xy[d]   = 8'h00;
            end else if ((req0 || req1) && (!m_have[d] || cyc >= m_g[d] + 17 + lat)) begin
`ifdef CHAR_ARB_FIXED_PRIO_EN
                w = req1 && !req0;
`else
                w = req1 && (!req0 || !m_last[d]);
`endif
                m_have[d] = 1'b1;
                m_g[d]    = cyc;
                m_own[d]  = w;
                m_row[d]  = w ? row1 : row0;
                m_last[d] = w;
            end
            mk   = m_have[d] ? cyc - m_g[d] : 999;
            g_e  = (mk == 0);
            bz_e = (mk <= 15 + lat);
            ov_e = (mk >= lat) && (mk <= lat + 15);
            dn_e = (mk == lat + 15);
            cl_e = ov_e ? 4'(mk - lat) : 4'h0;
            if (mk <= 15) m_xy[d] = {m_row[d], 4'(mk)};
            ev[d] = {g_e & ~m_own[d], g_e & m_own[d], bz_e, m_xy[d], ov_e, ov_e & m_own[d], cl_e,
                     dn_e & ~m_own[d], dn_e & m_own[d]};
            e_ov[d]   = ov_e;
            e_code[d] = {m_row[d][2:0], cl_e};
            m_k[d]    = mk;
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req0 = 1'b1; req1 = 1'b1; row0 = 4'h5; row1 = 4'hA;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                total++;
                if (dv[d] !== 19'h0) begin
                    bad++; $display("FAIL reset d%0d cyc=%0d got=%h want=%h", d, cyc, dv[d], 19'h0);
                end
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_tie();
        int gc[$];
        bit gi[$];
        bit exp_id [3];
`ifdef CHAR_ARB_FIXED_PRIO_EN
        exp_id = '{0, 0, 0};
`else
        exp_id = '{1, 0, 1};
`endif
        for (int n = 0; n < 70; n++) begin
            @(posedge clk); #1;
            if (gnt0_o[0] || gnt1_o[0]) begin gc.push_back(cyc); gi.push_back(gnt1_o[0]); end
            for (int d = 0; d < 3; d++) begin
                total++;
                if (dv[d] !== ev[d]) begin
                    bad++; $display("FAIL tie d%0d cyc=%0d got=%h want=%h", d, cyc, dv[d], ev[d]);
                end
                if (e_ov[d]) begin
                    total++;
                    if (code_o[d] !== e_code[d]) begin
                        bad++; $display("FAIL tie_code d%0d cyc=%0d got=%h want=%h", d, cyc, code_o[d], e_code[d]);
                    end
                end
            end
            @(negedge clk);
            if (n == 44) req0 = 1'b0;
        end
        req1 = 1'b0;
        total++;
        if (gc.size() < 3) begin
            bad++; $display("FAIL tie_count got=%0d want>=3", gc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (gi[i] !== exp_id[i]) begin
                    bad++; $display("FAIL tie_order idx=%0d got=%0d want=%0d", i, gi[i], exp_id[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                total++;
                if (gc[i] - gc[i-1] != 19) begin
                    bad++; $display("FAIL tie_spacing idx=%0d got=%0d want=19", i, gc[i] - gc[i-1]);
                end
            end
        end
    endtask

    task automatic test_quiet(input int cycles);
        req0 = 1'b0; req1 = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                total++;
                if (dv[d] !== ev[d]) begin
                    bad++; $display("FAIL quiet d%0d cyc=%0d got=%h want=%h", d, cyc, dv[d], ev[d]);
                end
            end
            @(negedge clk);
        end
    endtask

    // Single request on row 3; optionally switch row0 to 9 at column 5
    task automatic test_single(input bit change_row);
        req0 = 1'b1; row0 = 4'h3; req1 = 1'b0;
        for (int n = 0; n < 26; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                total++;
                if (dv[d] !== ev[d]) begin
                    bad++; $display("FAIL single d%0d row_chg=%0d cyc=%0d got=%h want=%h", d, change_row, cyc, dv[d], ev[d]);
                end
                if (e_ov[d]) begin
                    total++;
                    if (code_o[d] !== e_code[d]) begin
                        bad++; $display("FAIL single_code d%0d cyc=%0d got=%h want=%h", d, cyc, code_o[d], e_code[d]);
                    end
                end
            end
            @(negedge clk);
            if (m_k[0] == 0) req0 = 1'b0;
            if (change_row && m_k[0] == 5) row0 = 4'h9;
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; row0 = 4'h3; req1 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                total++;
                if (dv[d] !== ev[d]) begin
                    bad++; $display("FAIL reset_mid d%0d cyc=%0d got=%h want=%h", d, cyc, dv[d], ev[d]);
                end
            end
            total++;
            if (!rst_n && dv[0] !== 19'h0) begin
                bad++; $display("FAIL reset_mid_vals cyc=%0d got=%h want=%h", cyc, dv[0], 19'h0);
            end else if (rst_n && n > 9 && ov_o !== 3'b000) begin
                bad++; $display("FAIL reset_mid_stale cyc=%0d got=%b want=000", cyc, ov_o);
            end
            @(negedge clk);
            if (m_k[0] == 0) req0 = 1'b0;
            rst_n = !(m_have[0] && m_k[0] == 7);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            req0 = ($urandom_range(0, 3) == 0);
            req1 = ($urandom_range(0, 3) == 0);
            row0 = 4'($urandom_range(0, 15));
            row1 = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                total++;
                if (dv[d] !== ev[d]) begin
                    bad++; $display("FAIL random d%0d cyc=%0d got=%h want=%h", d, cyc, dv[d], ev[d]);
                end
                if (e_ov[d]) begin
                    total++;
                    if (code_o[d] !== e_code[d]) begin
                        bad++; $display("FAIL random_code d%0d cyc=%0d got=%h want=%h", d, cyc, code_o[d], e_code[d]);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_quiet(25);
        test_single(1'b0);
        test_quiet(25);
        test_single(1'b1);
        test_quiet(25);
        test_reset_mid();
        test_quiet(5);
        test_random(800);
        test_quiet(25);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
